// File: rtl/maze_navigator_if.sv
// Sensing/command handshake between a wall-sensor front end and maze_navigator.
interface maze_navigator_if;
  logic       sense_valid;
  logic       left;
  logic       mid;
  logic       right;
  logic [2:0] move;
  logic       move_valid;

  modport master (output sense_valid, left, mid, right, input move, move_valid);
  modport slave  (input sense_valid, left, mid, right, output move, move_valid);
endinterface

// File: rtl/maze_navigator.sv
// Wall-following maze navigator: one move per accepted wall sample, STOP at the exit.
// Optional macro VISIT_TRACK_EN adds per-cell visit counters and least-visited selection.
module maze_navigator #(
  parameter int ROWS       = 9,
  parameter int COLS       = 9,
  parameter int START_X    = 4,
  parameter int START_Y    = 8,
  parameter int START_HEAD = 0,
  parameter int EXIT_X     = 4,
  parameter int EXIT_Y     = 0,
  parameter int HAND       = 0,
  parameter int DE_W       = 8,
  localparam int XW        = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int YW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  maze_navigator_if.slave     nav,
  output logic [XW-1:0]       pos_x,
  output logic [YW-1:0]       pos_y,
  output logic [1:0]          heading,
  output logic                done,
  output logic [DE_W-1:0]     deadend_count
);

  localparam logic [2:0] MV_STOP  = 3'b000;
  localparam logic [2:0] MV_FWD   = 3'b001;
  localparam logic [2:0] MV_LEFT  = 3'b010;
  localparam logic [2:0] MV_RIGHT = 3'b011;
  localparam logic [2:0] MV_UTURN = 3'b100;

  if (START_X < 0 || START_X >= COLS || START_Y < 0 || START_Y >= ROWS ||
      EXIT_X < 0 || EXIT_X >= COLS || EXIT_Y < 0 || EXIT_Y >= ROWS ||
      START_HEAD < 0 || START_HEAD > 3) begin : g_bad_params
    $error("maze_navigator: START/EXIT outside grid or START_HEAD > 3");
  end

  typedef enum logic {S_RUN, S_DONE} state_t;
  state_t state;

  logic [2:0] move_p1;
  logic       vld_p1;

  function automatic logic [DE_W-1:0] sat_inc_de(input logic [DE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (&v) ? v : v + 2'd1;
  endfunction

  // Grid boundary seen as a wall in absolute direction d (0 N, 1 E, 2 S, 3 W).
  function automatic logic edge_wall(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                     input logic [1:0] d);
    case (d)
      2'd0:    return y == '0;
      2'd1:    return x == XW'(COLS - 1);
      2'd2:    return y == YW'(ROWS - 1);
      default: return x == '0;
    endcase
  endfunction

  function automatic logic [XW-1:0] nbr_x(input logic [XW-1:0] x, input logic [1:0] d);
    case (d)
      2'd1:    return x + XW'(1);
      2'd3:    return x - XW'(1);
      default: return x;
    endcase
  endfunction

  function automatic logic [YW-1:0] nbr_y(input logic [YW-1:0] y, input logic [1:0] d);
    case (d)
      2'd0:    return y - YW'(1);
      2'd2:    return y + YW'(1);
      default: return y;
    endcase
  endfunction

`ifdef VISIT_TRACK_EN
  localparam int NCELL = ROWS * COLS;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;

  logic [1:0]    visits [NCELL];
  logic [1:0]    nbr_cnt [3];
  logic [1:0]    best_cnt;
  logic [IW-1:0] ent_idx;

  // Out-of-grid neighbours are masked as walls, so their count is never used.
  function automatic logic [1:0] cnt_at(input logic [XW-1:0] x, input logic [YW-1:0] y);
    if (int'(x) < COLS && int'(y) < ROWS)
      return visits[IW'(int'(y) * COLS + int'(x))];
    return 2'd0;
  endfunction
`endif

  logic [1:0]    dir_rel [3];
  logic [2:0]    wall_s;
  logic [2:0]    open_rel;
  logic          sel_found;
  logic [1:0]    sel_k;
  logic [1:0]    kk;
  logic [2:0]    cmd;
  logic [1:0]    nh;
  logic          dead;
  logic          adv;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          at_exit;

  // Relative index 0 = left, 1 = mid, 2 = right; scan order follows the hand rule.
  always_comb begin
    wall_s    = {nav.right, nav.mid, nav.left};
    dir_rel[0] = heading - 2'd1;
    dir_rel[1] = heading;
    dir_rel[2] = heading + 2'd1;
    open_rel  = '0;
    sel_found = 1'b0;
    sel_k     = 2'd0;
    kk        = 2'd0;
`ifdef VISIT_TRACK_EN
    best_cnt  = 2'd3;
`endif
    for (int k = 0; k < 3; k++) begin
      open_rel[k] = ~(wall_s[k] | edge_wall(pos_x, pos_y, dir_rel[k]));
`ifdef VISIT_TRACK_EN
      nbr_cnt[k] = cnt_at(nbr_x(pos_x, dir_rel[k]), nbr_y(pos_y, dir_rel[k]));
`endif
    end
    for (int i = 0; i < 3; i++) begin
      kk = (HAND == 0) ? 2'(i) : 2'(2 - i);
      if (open_rel[kk]) begin
`ifdef VISIT_TRACK_EN
        if (!sel_found || nbr_cnt[kk] < best_cnt) begin
          sel_found = 1'b1;
          sel_k     = kk;
          best_cnt  = nbr_cnt[kk];
        end
`else
        if (!sel_found) begin
          sel_found = 1'b1;
          sel_k     = kk;
        end
`endif
      end
    end
  end

  // A U-turn whose back cell lies outside the grid rotates in place.
  always_comb begin
    dead = 1'b0;
    cmd  = MV_FWD;
    nh   = heading;
    if (sel_found) begin
      case (sel_k)
        2'd0:    begin cmd = MV_LEFT;  nh = dir_rel[0]; end
        2'd2:    begin cmd = MV_RIGHT; nh = dir_rel[2]; end
        default: begin cmd = MV_FWD;   nh = heading;    end
      endcase
    end else begin
      cmd  = MV_UTURN;
      nh   = heading + 2'd2;
      dead = 1'b1;
    end
    adv     = ~edge_wall(pos_x, pos_y, nh);
    nx      = adv ? nbr_x(pos_x, nh) : pos_x;
    ny      = adv ? nbr_y(pos_y, nh) : pos_y;
    at_exit = (pos_x == XW'(EXIT_X)) && (pos_y == YW'(EXIT_Y));
`ifdef VISIT_TRACK_EN
    ent_idx = IW'(int'(ny) * COLS + int'(nx));
`endif
  end

  // p0: sample accepted; p1: registered command, pose and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RUN;
      move_p1       <= MV_STOP;
      vld_p1        <= 1'b0;
      pos_x         <= XW'(START_X);
      pos_y         <= YW'(START_Y);
      heading       <= 2'(START_HEAD);
      done          <= 1'b0;
      deadend_count <= '0;
`ifdef VISIT_TRACK_EN
      for (int c = 0; c < NCELL; c++) visits[c] <= 2'd0;
`endif
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        S_RUN: begin
          if (nav.sense_valid) begin
            vld_p1 <= 1'b1;
            if (at_exit) begin
              move_p1 <= MV_STOP;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              move_p1 <= cmd;
              heading <= nh;
              pos_x   <= nx;
              pos_y   <= ny;
              if (dead) deadend_count <= sat_inc_de(deadend_count);
`ifdef VISIT_TRACK_EN
              if (adv) visits[ent_idx] <= sat_inc2(visits[ent_idx]);
`endif
            end
          end
        end
        default: move_p1 <= MV_STOP;
      endcase
    end
  end

  assign nav.move       = move_p1;
  assign nav.move_valid = vld_p1;

endmodule
